// File: rtl/median3_h_filter.sv
// -----------------------------------------------------------------------------
// median3_h_filter
//   Horizontal 3-tap median filter for a video pixel stream. s_tuser marks the
//   first pixel of a frame, s_tlast the last pixel of a line. Each colour
//   component is filtered independently as an unsigned value. Line edges are
//   handled by replicating the edge pixel, so the first output uses
//   med(p0,p0,p1) and the last uses med(pN-2,pN-1,pN-1).
//
//   The filter enable is sampled only on the first pixel of a frame. While
//   disabled, the centre pixel is forwarded through the same pipeline, so the
//   output timing is identical whether or not the filter is active.
//
//   Pipeline: a two-deep pixel history (prev, cur) plus one output register.
//   Output pixel n is loaded when input pixel n+1 arrives. The last pixel of
//   a line is emitted by a dedicated FLUSH cycle, which is the single input
//   bubble per line.
// -----------------------------------------------------------------------------
module median3_h_filter #(
    parameter int PX_WIDTH = 10,
    parameter int COMP_CNT = 3
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         en_i,
    input  logic                         s_tvalid,
    output logic                         s_tready,
    input  logic [PX_WIDTH*COMP_CNT-1:0] s_tdata,
    input  logic                         s_tuser,
    input  logic                         s_tlast,
    output logic                         m_tvalid,
    input  logic                         m_tready,
    output logic [PX_WIDTH*COMP_CNT-1:0] m_tdata,
    output logic                         m_tuser,
    output logic                         m_tlast
);

    localparam int TDATA_W = PX_WIDTH * COMP_CNT;

    // EMPTY : no pixel of the current line is held
    // HOLD  : at least one pixel held, waiting for its right neighbour
    // FLUSH : end of line seen, last pixel still to be emitted
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HOLD  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // Median helpers
    // -------------------------------------------------------------------------

    // Unsigned median of three: max(min(a,b), min(max(a,b),c)).
    function automatic logic [PX_WIDTH-1:0] med3_comp(
        input logic [PX_WIDTH-1:0] a,
        input logic [PX_WIDTH-1:0] b,
        input logic [PX_WIDTH-1:0] c
    );
        logic [PX_WIDTH-1:0] lo_ab;
        logic [PX_WIDTH-1:0] hi_ab;
        logic [PX_WIDTH-1:0] lo_hc;
        if (a < b) begin
            lo_ab = a;
            hi_ab = b;
        end else begin
            lo_ab = b;
            hi_ab = a;
        end
        if (hi_ab < c) begin
            lo_hc = hi_ab;
        end else begin
            lo_hc = c;
        end
        if (lo_ab > lo_hc) begin
            return lo_ab;
        end else begin
            return lo_hc;
        end
    endfunction

    // Component-wise median of three packed pixels.
    function automatic logic [TDATA_W-1:0] med3_pix(
        input logic [TDATA_W-1:0] a,
        input logic [TDATA_W-1:0] b,
        input logic [TDATA_W-1:0] c
    );
        logic [TDATA_W-1:0] res;
        res = '0;
        for (int k = 0; k < COMP_CNT; k++) begin
            res[k*PX_WIDTH +: PX_WIDTH] = med3_comp(a[k*PX_WIDTH +: PX_WIDTH],
                                                    b[k*PX_WIDTH +: PX_WIDTH],
                                                    c[k*PX_WIDTH +: PX_WIDTH]);
        end
        return res;
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t               r_state;
    logic [TDATA_W-1:0]   r_prev;
    logic [TDATA_W-1:0]   r_cur;
    logic                 r_cur_sof;
    logic                 r_en_frame;

    logic                 r_out_valid;
    logic [TDATA_W-1:0]   r_out_data;
    logic                 r_out_user;
    logic                 r_out_last;

    // -------------------------------------------------------------------------
    // Combinational control
    // -------------------------------------------------------------------------
    state_t               w_state_nxt;
    logic                 w_out_free;
    logic                 w_s_tready;
    logic                 w_accept;
    logic                 w_load;
    logic [TDATA_W-1:0]   w_load_data;
    logic                 w_load_user;
    logic                 w_load_last;
    logic                 w_hist_first;
    logic                 w_hist_shift;
    logic                 w_latch_en;
    logic [TDATA_W-1:0]   w_med_mid;
    logic [TDATA_W-1:0]   w_med_edge;

    // Median candidates: interior pixel (right neighbour is the incoming beat)
    // and last pixel of the line (right neighbour replicated from cur).
    always_comb begin
        w_med_mid  = med3_pix(r_prev, r_cur, s_tdata);
        w_med_edge = med3_pix(r_prev, r_cur, r_cur);
    end

    // Output slot is free when it is empty or being drained this cycle; input
    // is accepted only when the FSM can place the resulting output.
    always_comb begin
        w_out_free = (!r_out_valid) || m_tready;
        w_s_tready = 1'b0;
        case (r_state)
            ST_EMPTY: w_s_tready = 1'b1;
            ST_HOLD:  w_s_tready = w_out_free;
            ST_FLUSH: w_s_tready = 1'b0;
            default:  w_s_tready = 1'b0;
        endcase
        w_accept = s_tvalid && w_s_tready;
    end

    // FSM next state, output-register load and pixel-history control.
    always_comb begin
        w_state_nxt  = r_state;
        w_load       = 1'b0;
        w_load_data  = r_cur;
        w_load_user  = r_cur_sof;
        w_load_last  = 1'b0;
        w_hist_first = 1'b0;
        w_hist_shift = 1'b0;
        w_latch_en   = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_hist_first = 1'b1;
                    w_latch_en   = s_tuser;
                    if (s_tlast) begin
                        w_state_nxt = ST_FLUSH;
                    end else begin
                        w_state_nxt = ST_HOLD;
                    end
                end else begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_HOLD: begin
                if (w_accept) begin
                    w_load       = 1'b1;
                    w_load_data  = r_en_frame ? w_med_mid : r_cur;
                    w_load_user  = r_cur_sof;
                    w_load_last  = 1'b0;
                    w_hist_shift = 1'b1;
                    if (s_tlast) begin
                        w_state_nxt = ST_FLUSH;
                    end else begin
                        w_state_nxt = ST_HOLD;
                    end
                end else begin
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_FLUSH: begin
                if (w_out_free) begin
                    w_load      = 1'b1;
                    w_load_data = r_en_frame ? w_med_edge : r_cur;
                    w_load_user = r_cur_sof;
                    w_load_last = 1'b1;
                    w_state_nxt = ST_EMPTY;
                end else begin
                    w_state_nxt = ST_FLUSH;
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Sequential logic
    // -------------------------------------------------------------------------

    // FSM state register; reset drops any partially received line.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Pixel history: the first pixel of a line fills both taps (left-edge
    // replication), later pixels shift the window by one.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_prev    <= '0;
            r_cur     <= '0;
            r_cur_sof <= 1'b0;
        end else if (w_hist_first) begin
            r_prev    <= s_tdata;
            r_cur     <= s_tdata;
            r_cur_sof <= s_tuser;
        end else if (w_hist_shift) begin
            r_prev    <= r_cur;
            r_cur     <= s_tdata;
            r_cur_sof <= s_tuser;
        end else begin
            r_prev    <= r_prev;
            r_cur     <= r_cur;
            r_cur_sof <= r_cur_sof;
        end
    end

    // Frame-level enable, sampled on the first pixel of a frame only.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_en_frame <= 1'b1;
        end else if (w_latch_en) begin
            r_en_frame <= en_i;
        end else begin
            r_en_frame <= r_en_frame;
        end
    end

    // Output register: loads a new pixel, drains on m_tready, holds on stall.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_user  <= 1'b0;
            r_out_last  <= 1'b0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_load_data;
            r_out_user  <= w_load_user;
            r_out_last  <= w_load_last;
        end else if (m_tready) begin
            r_out_valid <= 1'b0;
            r_out_data  <= r_out_data;
            r_out_user  <= r_out_user;
            r_out_last  <= r_out_last;
        end else begin
            r_out_valid <= r_out_valid;
            r_out_data  <= r_out_data;
            r_out_user  <= r_out_user;
            r_out_last  <= r_out_last;
        end
    end

    assign s_tready = w_s_tready;
    assign m_tvalid = r_out_valid;
    assign m_tdata  = r_out_data;
    assign m_tuser  = r_out_user;
    assign m_tlast  = r_out_last;

endmodule

// File: tb/tb_median3_h_filter.sv
// -----------------------------------------------------------------------------
// tb_median3_h_filter
//   Directed table of pixels with hand-computed medians (component 0 carries
//   the table value v, component 1 carries 1023-v, component 2 carries 2v+1,
//   all monotone so the median maps through), followed by a mid-line reset
//   sequence and a randomised-backpressure stream checked against a model.
// -----------------------------------------------------------------------------
module tb_median3_h_filter;

    localparam int PXW = 10;
    localparam int CC  = 3;
    localparam int TW  = PXW * CC;
    localparam int NV  = 26;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          en_i;
    logic          s_tvalid;
    logic          s_tready;
    logic [TW-1:0] s_tdata;
    logic          s_tuser;
    logic          s_tlast;
    logic          m_tvalid;
    logic          m_tready;
    logic [TW-1:0] m_tdata;
    logic          m_tuser;
    logic          m_tlast;

    median3_h_filter #(.PX_WIDTH(PXW), .COMP_CNT(CC)) dut (
        .clk_i    (clk),
        .rst_i    (rst_i),
        .en_i     (en_i),
        .s_tvalid (s_tvalid),
        .s_tready (s_tready),
        .s_tdata  (s_tdata),
        .s_tuser  (s_tuser),
        .s_tlast  (s_tlast),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .m_tdata  (m_tdata),
        .m_tuser  (m_tuser),
        .m_tlast  (m_tlast)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [TW-1:0] data;
        logic          user;
        logic          last;
        int            cyc;
    } beat_t;

    typedef struct {
        logic en;
        logic user;
        logic last;
        int   in_v;
        int   exp_v;
        logic exp_user;
        logic exp_last;
    } vec_t;

    vec_t  vt [NV];
    int    tin [NV];
    beat_t got_q[$];
    beat_t exp_q[$];

    int    n_vec = 0;
    int    n_err = 0;
    int    cyc   = 0;
    logic  rand_rdy = 1'b0;

    logic          stall_pend = 1'b0;
    logic [TW-1:0] st_data;
    logic          st_user;
    logic          st_last;

    always @(posedge clk) cyc <= cyc + 1;

    // Random downstream backpressure when enabled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) m_tready = ($urandom_range(0, 3) != 0);
        end
    end

    // Output monitor: capture transfers and check stability under stall.
    always @(negedge clk) begin
        if (stall_pend && !rst_i) begin
            n_vec++;
            if (!(m_tvalid === 1'b1 && m_tdata === st_data && m_tuser === st_user && m_tlast === st_last)) begin
                n_err++;
                $display("FAIL stall_stable: got v=%b d=%h u=%b l=%b, want v=1 d=%h u=%b l=%b",
                         m_tvalid, m_tdata, m_tuser, m_tlast, st_data, st_user, st_last);
            end
        end
        stall_pend = m_tvalid && !m_tready;
        st_data    = m_tdata;
        st_user    = m_tuser;
        st_last    = m_tlast;
        if (m_tvalid && m_tready) begin
            beat_t b;
            b.data = m_tdata;
            b.user = m_tuser;
            b.last = m_tlast;
            b.cyc  = cyc;
            got_q.push_back(b);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [TW-1:0] pk(input int v);
        logic [PXW-1:0] c0;
        logic [PXW-1:0] c1;
        logic [PXW-1:0] c2;
        c0 = PXW'(v);
        c1 = PXW'(1023 - v);
        c2 = PXW'(2 * v + 1);
        return {c2, c1, c0};
    endfunction

    // Reference median: sum minus max minus min, per component.
    function automatic logic [TW-1:0] ref_med(input logic [TW-1:0] a, input logic [TW-1:0] b,
                                              input logic [TW-1:0] c);
        logic [TW-1:0] r;
        int x, y, z, mx, mn;
        r = '0;
        for (int k = 0; k < CC; k++) begin
            x = int'(a[k*PXW +: PXW]);
            y = int'(b[k*PXW +: PXW]);
            z = int'(c[k*PXW +: PXW]);
            mx = x; if (y > mx) mx = y; if (z > mx) mx = z;
            mn = x; if (y < mn) mn = y; if (z < mn) mn = z;
            r[k*PXW +: PXW] = PXW'(x + y + z - mx - mn);
        end
        return r;
    endfunction

    task automatic set_vec(input int i, input logic en, input logic u, input logic l,
                           input int inv, input int expv);
        vt[i].en       = en;
        vt[i].user     = u;
        vt[i].last     = l;
        vt[i].in_v     = inv;
        vt[i].exp_v    = expv;
        vt[i].exp_user = u;
        vt[i].exp_last = l;
    endtask

    task automatic push_exp(input logic [TW-1:0] d, input logic u, input logic l);
        beat_t b;
        b.data = d;
        b.user = u;
        b.last = l;
        b.cyc  = 0;
        exp_q.push_back(b);
    endtask

    // Present one beat (called at posedge+1) and hold it until accepted.
    task automatic send(input logic [TW-1:0] d, input logic u, input logic l, input logic e,
                        output int stamp);
        int   guard;
        logic acc;
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tuser  = u;
        s_tlast  = l;
        en_i     = e;
        guard    = 0;
        acc      = 1'b0;
        stamp    = -1;
        while (!acc && guard < 1000) begin
            @(negedge clk);
            guard++;
            if (s_tready) begin
                acc   = 1'b1;
                stamp = cyc;
            end
        end
        if (!acc) begin
            n_vec++;
            n_err++;
            $display("FAIL send_timeout: s_tready stayed %b, required 1", s_tready);
        end
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        s_tuser  = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic wait_out(input int n, input int budget);
        int g;
        g = 0;
        while (got_q.size() < n && g < budget) begin
            @(posedge clk);
            g++;
        end
        repeat (4) @(posedge clk);
        #1;
        if (got_q.size() < n) begin
            n_vec++;
            n_err++;
            $display("FAIL out_timeout: got %0d beats, required %0d", got_q.size(), n);
        end
    endtask

    task automatic check_beats(input string tag);
        n_vec++;
        if (got_q.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL %s beat_count: got %0d, required %0d", tag, got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_vec++;
            if (got_q[i].data !== exp_q[i].data || got_q[i].user !== exp_q[i].user ||
                got_q[i].last !== exp_q[i].last) begin
                n_err++;
                $display("FAIL %s beat %0d: got d=%h u=%b l=%b, required d=%h u=%b l=%b", tag, i,
                         got_q[i].data, got_q[i].user, got_q[i].last,
                         exp_q[i].data, exp_q[i].user, exp_q[i].last);
            end
        end
    endtask

    initial begin
        int st;
        logic [TW-1:0] line [64];
        logic [TW-1:0] lft;
        logic [TW-1:0] rgt;
        logic [TW-1:0] ex;
        logic          fen;

        rst_i    = 1'b1;
        en_i     = 1'b0;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        s_tuser  = 1'b0;
        s_tlast  = 1'b0;
        m_tready = 1'b1;

        // Filtered line, then the same line bypassed.
        set_vec(0, 1'b1, 1'b1, 1'b0, 10, 10);
        set_vec(1, 1'b1, 1'b0, 1'b0, 50, 20);
        set_vec(2, 1'b1, 1'b0, 1'b0, 20, 30);
        set_vec(3, 1'b1, 1'b0, 1'b1, 30, 30);
        set_vec(4, 1'b0, 1'b1, 1'b0, 10, 10);
        set_vec(5, 1'b0, 1'b0, 1'b0, 50, 50);
        set_vec(6, 1'b0, 1'b0, 1'b0, 20, 20);
        set_vec(7, 1'b0, 1'b0, 1'b1, 30, 30);
        // Frame with en dropping after the first pixel: both lines filtered.
        set_vec(8,  1'b1, 1'b1, 1'b0, 100, 100);
        set_vec(9,  1'b0, 1'b0, 1'b0, 5,   100);
        set_vec(10, 1'b0, 1'b0, 1'b0, 200, 7);
        set_vec(11, 1'b0, 1'b0, 1'b0, 7,   9);
        set_vec(12, 1'b0, 1'b0, 1'b1, 9,   9);
        set_vec(13, 1'b0, 1'b0, 1'b0, 3,   3);
        set_vec(14, 1'b0, 1'b0, 1'b0, 8,   3);
        set_vec(15, 1'b0, 1'b0, 1'b1, 1,   1);
        // Next frame latched disabled; en rising mid-frame is ignored.
        set_vec(16, 1'b0, 1'b1, 1'b0, 3,  3);
        set_vec(17, 1'b0, 1'b0, 1'b0, 8,  8);
        set_vec(18, 1'b0, 1'b0, 1'b1, 1,  1);
        set_vec(19, 1'b1, 1'b0, 1'b0, 60, 60);
        set_vec(20, 1'b1, 1'b0, 1'b0, 2,  2);
        set_vec(21, 1'b1, 1'b0, 1'b1, 61, 61);
        // One-pixel frame/line, then a line still filtered though en_i=0.
        set_vec(22, 1'b1, 1'b1, 1'b1, 77, 77);
        set_vec(23, 1'b0, 1'b0, 1'b0, 40, 40);
        set_vec(24, 1'b0, 1'b0, 1'b0, 90, 40);
        set_vec(25, 1'b0, 1'b0, 1'b1, 5,  5);

        repeat (3) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (m_tvalid !== 1'b0 || m_tdata !== '0 || m_tuser !== 1'b0 || m_tlast !== 1'b0) begin
            n_err++;
            $display("FAIL reset_out: got v=%b d=%h u=%b l=%b, required all 0",
                     m_tvalid, m_tdata, m_tuser, m_tlast);
        end
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        @(negedge clk);
        n_vec++;
        if (s_tready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_ready: got %b, required 1", s_tready);
        end
        @(posedge clk);
        #1;

        // ---------------- Table phase ----------------
        for (int i = 0; i < NV; i++) begin
            send(pk(vt[i].in_v), vt[i].user, vt[i].last, vt[i].en, st);
            tin[i] = st;
            push_exp(pk(vt[i].exp_v), vt[i].exp_user, vt[i].exp_last);
        end
        wait_out(NV, 300);
        check_beats("table");
        for (int i = 0; i < NV && i < got_q.size(); i++) begin
            n_vec++;
            if (got_q[i].cyc - tin[i] != 2) begin
                n_err++;
                $display("FAIL latency pixel %0d: got %0d cycles, required 2", i, got_q[i].cyc - tin[i]);
            end
        end
        for (int i = 1; i < NV; i++) begin
            if (vt[i-1].last) begin
                n_vec++;
                if (tin[i] - tin[i-1] != 2) begin
                    n_err++;
                    $display("FAIL line_bubble at %0d: got gap %0d, required 2", i, tin[i] - tin[i-1]);
                end
            end
        end
        got_q.delete();
        exp_q.delete();

        // ---------------- Reset after 3 pixels ----------------
        send(pk(10), 1'b1, 1'b0, 1'b1, st);
        send(pk(50), 1'b0, 1'b0, 1'b1, st);
        send(pk(20), 1'b0, 1'b0, 1'b1, st);
        push_exp(pk(10), 1'b1, 1'b0);
        push_exp(pk(20), 1'b0, 1'b0);
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        @(negedge clk);
        n_vec++;
        if (m_tvalid !== 1'b0 || s_tready !== 1'b1) begin
            n_err++;
            $display("FAIL midline_reset: got m_tvalid=%b s_tready=%b, required 0 and 1", m_tvalid, s_tready);
        end
        @(posedge clk);
        #1;
        send(pk(30), 1'b1, 1'b0, 1'b1, st);
        send(pk(5),  1'b0, 1'b0, 1'b1, st);
        send(pk(60), 1'b0, 1'b0, 1'b1, st);
        send(pk(40), 1'b0, 1'b0, 1'b1, st);
        send(pk(45), 1'b0, 1'b1, 1'b1, st);
        push_exp(pk(30), 1'b1, 1'b0);
        push_exp(pk(30), 1'b0, 1'b0);
        push_exp(pk(40), 1'b0, 1'b0);
        push_exp(pk(45), 1'b0, 1'b0);
        push_exp(pk(45), 1'b0, 1'b1);
        wait_out(7, 200);
        check_beats("reset_line");
        got_q.delete();
        exp_q.delete();

        // ---------------- Random gaps and backpressure ----------------
        rand_rdy = 1'b1;
        for (int f = 0; f < 2; f++) begin
            fen = (f == 0);
            for (int l = 0; l < 4; l++) begin
                for (int p = 0; p < 64; p++) line[p] = TW'($urandom);
                for (int p = 0; p < 64; p++) begin
                    lft = line[(p == 0) ? 0 : p - 1];
                    rgt = line[(p == 63) ? 63 : p + 1];
                    ex  = fen ? ref_med(lft, line[p], rgt) : line[p];
                    push_exp(ex, (l == 0 && p == 0), (p == 63));
                end
                for (int p = 0; p < 64; p++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        repeat ($urandom_range(1, 2)) @(posedge clk);
                        #1;
                    end
                    send(line[p], (l == 0 && p == 0), (p == 63),
                         (l == 0 && p == 0) ? fen : 1'($urandom_range(0, 1)), st);
                end
            end
        end
        wait_out(512, 5000);
        rand_rdy = 1'b0;
        check_beats("random");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
